axi_serializer: RTL and testbench

Ready/valid stream width downsizer. It accepts one IN_WIDTH word from an upstream producer, such as an axi_fifo output, and transmits it as RATIO narrow beats to a downstream consumer. The block is the transmit side that feeds narrow links, for example framebuffer or memory write ports, from the wide rasterizer datapath. It sustains full throughput: RATIO beats per word with no bubble between words.

---
 rtl/axi_pkg.sv | 23 ++
 rtl/axi_beat_counter.sv | 32 +++
 rtl/axi_serializer.sv | 98 +++++++++
 tb/tb_axi_serializer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared definitions for the stream width downsizer: FSM state type,
// word/beat ratio derivation with its divisibility check, and the
// beat-index width helper.
package axi_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_e;

  // Beats per word; 0 flags a word width that is not a whole number of beats.
  function automatic int ser_ratio(input int in_w, input int out_w);
    if (out_w <= 0) return 0;
    if ((in_w % out_w) != 0) return 0;
    return in_w / out_w;
  endfunction

  // Width of a counter indexing 0..ratio-1 (never narrower than one bit).
  function automatic int beat_idx_w(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

endpackage

// File: rtl/axi_beat_counter.sv
// Modulo-RATIO beat counter: clear has priority over increment, tc flags
// the final beat index RATIO-1.
module axi_beat_counter
  import axi_pkg::*;
#(
  parameter int RATIO = 4,
  parameter int CNT_W = beat_idx_w(RATIO)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             tc
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(RATIO - 1);

  assign tc = (count == LAST_IDX);

  // Count beats; wrap only when incremented from the terminal value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= tc ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/axi_serializer.sv
// Ready/valid width downsizer: one IN_WIDTH word in, RATIO OUT_WIDTH beats
// out, LSB beat first, with no bubble between back-to-back words.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1; vld_out never drops before its beat is accepted, and rdy_in never
// depends combinationally on vld_in.
// Optional macro AXI_SERIALIZER_LAST_EN adds last_out, high on the final
// beat of every word.
module axi_serializer
  import axi_pkg::*;
#(
  parameter int IN_WIDTH  = 64,
  parameter int OUT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 vld_in,
  input  logic [IN_WIDTH-1:0]  data_in,
  output logic                 rdy_in,
  output logic                 vld_out,
  output logic [OUT_WIDTH-1:0] data_out,
  input  logic                 rdy_out
`ifdef AXI_SERIALIZER_LAST_EN
  ,
  output logic                 last_out
`endif
);

  localparam int RATIO = ser_ratio(IN_WIDTH, OUT_WIDTH);
  localparam int CNT_W = beat_idx_w(RATIO);

  generate
    if (RATIO < 2) begin : g_bad_ratio
      $error("axi_serializer: IN_WIDTH must be a multiple of OUT_WIDTH with at least 2 beats");
    end
  endgenerate

  ser_state_e          state;
  logic [IN_WIDTH-1:0] shift_q;
  logic [CNT_W-1:0]    beat;
  logic                beat_tc;
  logic                load;
  logic                beat_acc;

  // A new word may enter when idle, or when the final beat leaves this cycle.
  assign rdy_in   = (state == IDLE) || ((state == SEND) && beat_tc && rdy_out);
  assign load     = vld_in && rdy_in;
  assign beat_acc = (state == SEND) && rdy_out;

  assign vld_out  = (state == SEND);
  assign data_out = shift_q[OUT_WIDTH-1:0];

`ifdef AXI_SERIALIZER_LAST_EN
  assign last_out = vld_out && beat_tc;
`endif

  axi_beat_counter #(
    .RATIO (RATIO),
    .CNT_W (CNT_W)
  ) u_beat_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (load),
    .inc   (beat_acc && !beat_tc),
    .count (beat),
    .tc    (beat_tc)
  );

  // State and shift register: load a word, shift per accepted beat, and
  // either reload or drain to IDLE after the final beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      shift_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (vld_in) begin
            shift_q <= data_in;
            state   <= SEND;
          end
        end
        SEND: begin
          if (rdy_out) begin
            if (!beat_tc) begin
              shift_q <= shift_q >> OUT_WIDTH;
            end else if (vld_in) begin
              shift_q <= data_in;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_serializer.sv
// Bench for axi_serializer: directed per-cycle vector table followed by a
// randomized run checked against a beat-queue reference model.
// Build with AXI_SERIALIZER_LAST_EN defined to exercise last_out (32/8 split).
module tb_axi_serializer;

`ifdef AXI_SERIALIZER_LAST_EN
  localparam int IN_W  = 32;
  localparam int OUT_W = 8;
`else
  localparam int IN_W  = 64;
  localparam int OUT_W = 16;
`endif
  localparam int NBEAT = IN_W / OUT_W;

  logic             clk;
  logic             rst_n;
  logic             vld_in;
  logic [IN_W-1:0]  data_in;
  logic             rdy_in;
  logic             vld_out;
  logic [OUT_W-1:0] data_out;
  logic             rdy_out;
`ifdef AXI_SERIALIZER_LAST_EN
  logic             last_out;
`endif

  int n_cmp;
  int n_bad;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  axi_serializer #(
    .IN_WIDTH  (IN_W),
    .OUT_WIDTH (OUT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .vld_in   (vld_in),
    .data_in  (data_in),
    .rdy_in   (rdy_in),
    .vld_out  (vld_out),
    .data_out (data_out),
    .rdy_out  (rdy_out)
`ifdef AXI_SERIALIZER_LAST_EN
    ,
    .last_out (last_out)
`endif
  );

  // ---------------- vector table ----------------
  typedef struct {
    logic            rst_n;
    logic            vld_in;
    logic [IN_W-1:0] data_in;
    logic            rdy_out;
    logic            exp_vld;
    logic            chk_data;
    logic [OUT_W-1:0] exp_data;
    logic            exp_rdy_in;
    logic            exp_last;
    string           tag;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string tag, input logic r, input logic v,
                     input logic [IN_W-1:0] d, input logic ro,
                     input logic ev, input logic cd, input logic [OUT_W-1:0] ed,
                     input logic eri, input logic el);
    vec_t x;
    x.tag = tag; x.rst_n = r; x.vld_in = v; x.data_in = d; x.rdy_out = ro;
    x.exp_vld = ev; x.chk_data = cd; x.exp_data = ed; x.exp_rdy_in = eri;
    x.exp_last = el;
    vecs.push_back(x);
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Drive one cycle's inputs, compare outputs mid-cycle, then advance.
  task automatic apply(input vec_t x);
    rst_n   = x.rst_n;
    vld_in  = x.vld_in;
    data_in = x.data_in;
    rdy_out = x.rdy_out;
    #1;
    check({x.tag, ".vld_out"}, 64'(vld_out), 64'(x.exp_vld));
    check({x.tag, ".rdy_in"}, 64'(rdy_in), 64'(x.exp_rdy_in));
    if (x.chk_data) check({x.tag, ".data_out"}, 64'(data_out), 64'(x.exp_data));
`ifdef AXI_SERIALIZER_LAST_EN
    check({x.tag, ".last_out"}, 64'(last_out), 64'(x.exp_last));
`endif
    @(posedge clk);
    #1;
  endtask

  function automatic logic [IN_W-1:0] rand_word();
    logic [63:0] w;
    w = {$urandom(), $urandom()};
    return w[IN_W-1:0];
  endfunction

  logic [OUT_W-1:0] exp_q[$];

  initial begin
    logic [IN_W-1:0] w;
    logic            pending;
    logic            acc_in;
    logic            acc_out;
    int              vp;
    int              rp;

    n_cmp   = 0;
    n_bad   = 0;
    rst_n   = 1'b0;
    vld_in  = 1'b0;
    data_in = '0;
    rdy_out = 1'b0;
    repeat (2) @(posedge clk);
    #1;

`ifdef AXI_SERIALIZER_LAST_EN
    // Word 0xDDCCBBAA: last_out only with 0xDD, also while 0xDD is stalled.
    add("rst_state", 1, 1, 32'hDDCC_BBAA, 1, 0, 1, 8'h00, 1, 0);
    add("b0",        1, 0, '0,           1, 1, 1, 8'hAA, 0, 0);
    add("b1",        1, 0, '0,           1, 1, 1, 8'hBB, 0, 0);
    add("b2",        1, 0, '0,           1, 1, 1, 8'hCC, 0, 0);
    add("b3_stall0", 1, 1, 32'h1234_5678, 0, 1, 1, 8'hDD, 0, 1);
    add("b3_stall1", 1, 0, '0,           0, 1, 1, 8'hDD, 0, 1);
    add("b3_go",     1, 0, '0,           1, 1, 1, 8'hDD, 1, 1);
    add("idle",      1, 0, '0,           1, 0, 0, 8'h00, 1, 0);
`else
    // Single word with continuous downstream ready.
    add("rst_state", 1, 1, 64'h4444_3333_2222_1111, 1, 0, 1, 16'h0000, 1, 0);
    add("one.b0",    1, 0, '0, 1, 1, 1, 16'h1111, 0, 0);
    add("one.b1",    1, 0, '0, 1, 1, 1, 16'h2222, 0, 0);
    add("one.b2",    1, 0, '0, 1, 1, 1, 16'h3333, 0, 0);
    add("one.b3",    1, 0, '0, 1, 1, 1, 16'h4444, 1, 0);
    add("one.idle",  1, 0, '0, 1, 0, 0, 16'h0000, 1, 0);
    add("idle_rdy",  1, 0, '0, 1, 0, 0, 16'h0000, 1, 0);
    // Back-to-back A then B; B offered (blocked) during A's beats 0-2.
    add("b2b.ldA",   1, 1, 64'hA3A3_A2A2_A1A1_A0A0, 1, 0, 0, 16'h0, 1, 0);
    add("b2b.a0",    1, 1, 64'hB3B3_B2B2_B1B1_B0B0, 1, 1, 1, 16'hA0A0, 0, 0);
    add("b2b.a1",    1, 1, 64'hB3B3_B2B2_B1B1_B0B0, 1, 1, 1, 16'hA1A1, 0, 0);
    add("b2b.a2",    1, 1, 64'hB3B3_B2B2_B1B1_B0B0, 1, 1, 1, 16'hA2A2, 0, 0);
    add("b2b.a3",    1, 1, 64'hB3B3_B2B2_B1B1_B0B0, 1, 1, 1, 16'hA3A3, 1, 0);
    add("b2b.b0",    1, 0, '0, 1, 1, 1, 16'hB0B0, 0, 0);
    add("b2b.b1",    1, 0, '0, 1, 1, 1, 16'hB1B1, 0, 0);
    add("b2b.b2",    1, 0, '0, 1, 1, 1, 16'hB2B2, 0, 0);
    add("b2b.b3",    1, 0, '0, 1, 1, 1, 16'hB3B3, 1, 0);
    add("b2b.idle",  1, 0, '0, 1, 0, 0, 16'h0, 1, 0);
    // Stall for 3 cycles on beat 2, then a stall on beat 3 keeps rdy_in low.
    add("stl.ld",    1, 1, 64'h4444_3333_2222_1111, 1, 0, 0, 16'h0, 1, 0);
    add("stl.b0",    1, 0, '0, 1, 1, 1, 16'h1111, 0, 0);
    add("stl.b1",    1, 0, '0, 1, 1, 1, 16'h2222, 0, 0);
    add("stl.b2s0",  1, 0, '0, 0, 1, 1, 16'h3333, 0, 0);
    add("stl.b2s1",  1, 0, '0, 0, 1, 1, 16'h3333, 0, 0);
    add("stl.b2s2",  1, 0, '0, 0, 1, 1, 16'h3333, 0, 0);
    add("stl.b2",    1, 0, '0, 1, 1, 1, 16'h3333, 0, 0);
    add("stl.b3s",   1, 1, 64'h0F0F_0E0E_0D0D_0C0C, 0, 1, 1, 16'h4444, 0, 0);
    add("stl.b3",    1, 0, '0, 1, 1, 1, 16'h4444, 1, 0);
    add("stl.idle",  1, 0, '0, 0, 0, 0, 16'h0, 1, 0);
    // Reset during beat 1 discards the word; the next word starts at beat 0.
    add("rst.ld",    1, 1, 64'h4444_3333_2222_1111, 1, 0, 0, 16'h0, 1, 0);
    add("rst.b0",    1, 0, '0, 1, 1, 1, 16'h1111, 0, 0);
    add("rst.b1",    0, 0, '0, 1, 1, 1, 16'h2222, 0, 0);
    add("rst.after", 1, 1, 64'h8888_7777_6666_5555, 1, 0, 1, 16'h0000, 1, 0);
    add("rst.n0",    1, 0, '0, 1, 1, 1, 16'h5555, 0, 0);
    add("rst.n1",    1, 0, '0, 1, 1, 1, 16'h6666, 0, 0);
    add("rst.n2",    1, 0, '0, 1, 1, 1, 16'h7777, 0, 0);
    add("rst.n3",    1, 0, '0, 1, 1, 1, 16'h8888, 1, 0);
    add("rst.idle",  1, 0, '0, 1, 0, 0, 16'h0, 1, 0);
`endif

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

    // ---------------- randomized run vs. beat-queue model ----------------
    // Model: every accepted word expands into NBEAT LSB-first beats; a beat
    // is owed downstream while the queue is non-empty, and a word can enter
    // when nothing is owed or the single owed beat leaves this cycle.
    rst_n  = 1'b0;
    vld_in = 1'b0;
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    pending = 1'b0;
    exp_q.delete();
    for (int r = 0; r < 4; r++) begin
      vp = 30 + 20 * r;
      rp = 95 - 20 * r;
      for (int c = 0; c < 200; c++) begin
        if (!pending) begin
          vld_in  = ($urandom_range(99) < vp);
          data_in = rand_word();
        end
        rdy_out = ($urandom_range(99) < rp);
        #1;
        check("rnd.vld_out", 64'(vld_out), 64'(exp_q.size() != 0));
        check("rnd.rdy_in", 64'(rdy_in),
              64'((exp_q.size() == 0) || ((exp_q.size() == 1) && rdy_out)));
        if (exp_q.size() != 0) check("rnd.data_out", 64'(data_out), 64'(exp_q[0]));
`ifdef AXI_SERIALIZER_LAST_EN
        check("rnd.last_out", 64'(last_out), 64'(exp_q.size() == 1));
`endif
        acc_in  = vld_in && rdy_in;
        acc_out = vld_out && rdy_out;
        pending = vld_in && !acc_in;
        w       = data_in;
        @(posedge clk);
        #1;
        if (acc_out && (exp_q.size() != 0)) void'(exp_q.pop_front());
        if (acc_in) begin
          for (int k = 0; k < NBEAT; k++) exp_q.push_back(w[k*OUT_W +: OUT_W]);
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
